// File: rtl/booth_vote_scheduler.sv
// rtl/booth_vote_scheduler.sv - session FSM and round-robin vote arbiter feeding one tally port
// Optional per-booth arm timeout is enabled by defining VOTE_TIMEOUT_EN.
module booth_vote_scheduler #(
    parameter int NUM_BOOTHS     = 4,
    parameter int NUM_CAND       = 3,
    parameter int CW             = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_session_open,
    input  logic                          i_session_close,
    input  logic                          i_clear,
    input  logic [NUM_BOOTHS-1:0]         i_arm,
    input  logic [NUM_BOOTHS-1:0]         i_vote_req,
    input  logic [NUM_BOOTHS*CW-1:0]      i_vote_cand,
    input  logic                          i_vote_ready,
    output logic                          o_vote_valid,
    output logic [CW-1:0]                 o_vote_cand,
    output logic [$clog2(NUM_BOOTHS)-1:0] o_vote_booth,
    output logic [NUM_BOOTHS-1:0]         o_booth_armed,
    output logic [NUM_BOOTHS-1:0]         o_vote_ack,
    output logic [NUM_BOOTHS-1:0]         o_reject,
    output logic [NUM_BOOTHS-1:0]         o_timeout,
    output logic [1:0]                    o_state,
    output logic                          o_results_valid,
    output logic [15:0]                   o_total_votes
);
    localparam int BW = $clog2(NUM_BOOTHS);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_OPEN = 2'd1, S_DRAIN = 2'd2, S_CLOSED = 2'd3} state_t;

    state_t                state_q;
    logic [NUM_BOOTHS-1:0] armed_q, pending_q, ack_q, reject_q;
    logic [CW-1:0]         cand_q [NUM_BOOTHS];
    logic [BW-1:0]         ptr_q, vbooth_q;
    logic                  valid_q;
    logic [CW-1:0]         vcand_q;
    logic [15:0]           total_q;

`ifdef VOTE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         tcnt_q [NUM_BOOTHS];
    logic [NUM_BOOTHS-1:0] timeout_q;
    assign o_timeout = timeout_q;
`else
    assign o_timeout = '0;
`endif

    // Round-robin pick among pending booths, skipping the one already on the output.
    logic [NUM_BOOTHS-1:0] elig;
    logic                  found;
    logic [BW-1:0]         win, idx;
    int                    s;
    always_comb begin
        elig = pending_q;
        if (valid_q) elig[vbooth_q] = 1'b0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        s     = 0;
        for (int k = 0; k < NUM_BOOTHS; k++) begin
            s = int'(ptr_q) + k;
            if (s >= NUM_BOOTHS) s = s - NUM_BOOTHS;
            idx = BW'(s);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    logic handshake, slot_free;
    assign handshake = valid_q & i_vote_ready;
    assign slot_free = !valid_q || handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            armed_q   <= '0;
            pending_q <= '0;
            ack_q     <= '0;
            reject_q  <= '0;
            ptr_q     <= '0;
            vbooth_q  <= '0;
            valid_q   <= 1'b0;
            vcand_q   <= '0;
            total_q   <= '0;
            for (int b = 0; b < NUM_BOOTHS; b++) cand_q[b] <= '0;
`ifdef VOTE_TIMEOUT_EN
            timeout_q <= '0;
            for (int b = 0; b < NUM_BOOTHS; b++) tcnt_q[b] <= '0;
`endif
        end else begin
            ack_q    <= '0;
            reject_q <= '0;
`ifdef VOTE_TIMEOUT_EN
            timeout_q <= '0;
`endif
            case (state_q)
                S_IDLE: if (i_session_open) begin
                    state_q <= S_OPEN;
                    total_q <= '0;
                end
                S_OPEN: if (i_session_close) begin
                    state_q <= S_DRAIN;
                    armed_q <= '0;
                end else begin
                    for (int b = 0; b < NUM_BOOTHS; b++) begin
                        if (armed_q[b]) begin
                            if (i_vote_req[b] && int'(i_vote_cand[b*CW +: CW]) < NUM_CAND) begin
                                cand_q[b]    <= i_vote_cand[b*CW +: CW];
                                pending_q[b] <= 1'b1;
                                armed_q[b]   <= 1'b0;
                            end else begin
                                if (i_vote_req[b]) reject_q[b] <= 1'b1;
`ifdef VOTE_TIMEOUT_EN
                                if (tcnt_q[b] == TW'(TIMEOUT_CYCLES - 1)) begin
                                    armed_q[b]   <= 1'b0;
                                    timeout_q[b] <= 1'b1;
                                end else begin
                                    tcnt_q[b] <= tcnt_q[b] + 1'b1;
                                end
`endif
                            end
                        end else if (i_arm[b] && !pending_q[b]) begin
                            armed_q[b] <= 1'b1;
`ifdef VOTE_TIMEOUT_EN
                            tcnt_q[b]  <= '0;
`endif
                        end
                    end
                end
                S_DRAIN: if (pending_q == '0 && !valid_q) state_q <= S_CLOSED;
                default: if (i_clear) state_q <= S_IDLE;
            endcase

            if (handshake) begin
                pending_q[vbooth_q] <= 1'b0;
                ack_q[vbooth_q]     <= 1'b1;
                if (total_q != 16'hFFFF) total_q <= total_q + 16'd1;
            end
            if (slot_free) begin
                valid_q <= found;
                if (found) begin
                    vcand_q  <= cand_q[win];
                    vbooth_q <= win;
                    ptr_q    <= (int'(win) == NUM_BOOTHS - 1) ? '0 : win + 1'b1;
                end
            end
        end
    end

    assign o_vote_valid    = valid_q;
    assign o_vote_cand     = vcand_q;
    assign o_vote_booth    = vbooth_q;
    assign o_booth_armed   = armed_q;
    assign o_vote_ack      = ack_q;
    assign o_reject        = reject_q;
    assign o_state         = state_q;
    assign o_results_valid = (state_q == S_CLOSED);
    assign o_total_votes   = total_q;
endmodule

// File: tb/tb_booth_vote_scheduler.sv
// tb/tb_booth_vote_scheduler.sv - directed self-checking bench for booth_vote_scheduler
module tb_booth_vote_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        open_p, close_p, clear_p, ready;
    logic [3:0]  arm, req;
    logic [7:0]  cand;
    logic        v_valid;
    logic [1:0]  v_cand, v_booth, state;
    logic [3:0]  armed, ack, rej, tmo;
    logic        res_valid;
    logic [15:0] total;
    int          checks   = 0;
    int          failures = 0;

    booth_vote_scheduler #(.NUM_BOOTHS(4), .NUM_CAND(3), .CW(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_session_open(open_p), .i_session_close(close_p), .i_clear(clear_p),
        .i_arm(arm), .i_vote_req(req), .i_vote_cand(cand), .i_vote_ready(ready),
        .o_vote_valid(v_valid), .o_vote_cand(v_cand), .o_vote_booth(v_booth),
        .o_booth_armed(armed), .o_vote_ack(ack), .o_reject(rej), .o_timeout(tmo),
        .o_state(state), .o_results_valid(res_valid), .o_total_votes(total)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; open_p = 0; close_p = 0; clear_p = 0; ready = 0;
        arm = 0; req = 0; cand = 0;
        tick(); tick();
        chk("rst_state", state, 0);   chk("rst_valid", v_valid, 0);
        chk("rst_armed", armed, 0);   chk("rst_total", total, 0);
        chk("rst_results", res_valid, 0);
        rst = 1'b0;

        // single vote
        open_p = 1; tick(); open_p = 0;
        chk("open_state", state, 1);
        arm = 4'b0001; tick(); arm = 0;
        chk("arm_b0", armed, 4'b0001);
        req = 4'b0001; cand = 8'h01; ready = 1; tick(); req = 0;
        chk("latch_armed", armed, 0); chk("latch_valid", v_valid, 0);
        tick();
        chk("t1_valid", v_valid, 1); chk("t1_cand", v_cand, 1); chk("t1_booth", v_booth, 0);
        tick();
        chk("t1_valid_drop", v_valid, 0); chk("t1_ack", ack, 4'b0001); chk("t1_total", total, 1);
        tick();
        chk("t1_ack_pulse", ack, 0);

        // three booths latch together, fresh pointer
        rst = 1; tick(); rst = 0;
        open_p = 1; tick(); open_p = 0;
        chk("reopen_total", total, 0);
        arm = 4'b0111; tick(); arm = 0;
        req = 4'b0111; cand = 8'h18; tick(); req = 0;
        chk("t2_valid0", v_valid, 0);
        tick(); chk("t2_g0_booth", v_booth, 0); chk("t2_g0_cand", v_cand, 0);
        tick(); chk("t2_g1_booth", v_booth, 1); chk("t2_g1_cand", v_cand, 2); chk("t2_ack0", ack, 4'b0001);
        tick(); chk("t2_g2_booth", v_booth, 2); chk("t2_g2_cand", v_cand, 1); chk("t2_ack1", ack, 4'b0010);
        tick(); chk("t2_idle", v_valid, 0); chk("t2_ack2", ack, 4'b0100); chk("t2_total", total, 3);
        // pointer sits at 3, so booth 0 wraps ahead of booth 1
        arm = 4'b0011; tick(); arm = 0;
        req = 4'b0011; cand = 8'h02; tick(); req = 0;
        tick(); chk("t2_wrap_b0", v_booth, 0); chk("t2_wrap_c0", v_cand, 2);
        tick(); chk("t2_wrap_b1", v_booth, 1); chk("t2_wrap_c1", v_cand, 0);
        tick(); chk("t2_wrap_total", total, 5);

        // backpressure
        ready = 0;
        arm = 4'b1000; tick(); arm = 0;
        req = 4'b1000; cand = 8'h80; tick(); req = 0; cand = 8'h40;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", v_valid, 1); chk("bp_cand", v_cand, 2); chk("bp_booth", v_booth, 3);
            chk("bp_noack", ack, 0);
            tick();
        end
        ready = 1; tick();
        chk("bp_accept", v_valid, 0); chk("bp_ack", ack, 4'b1000); chk("bp_total", total, 6);

        // out-of-range candidate and unarmed request
        arm = 4'b0100; tick(); arm = 0;
        req = 4'b0100; cand = 8'h30; tick(); req = 0;
        chk("rej_pulse", rej, 4'b0100); chk("rej_armed", armed, 4'b0100);
        tick();
        chk("rej_clear", rej, 0); chk("rej_novalid", v_valid, 0);
        req = 4'b0010; cand = 8'h04; tick(); req = 0;
        chk("unarmed_norej", rej, 0); chk("unarmed_armed", armed, 4'b0100);

        // close with one pending and others armed
        ready = 0;
        arm = 4'b0011; tick(); arm = 0;
        chk("pre_close_armed", armed, 4'b0111);
        req = 4'b0001; cand = 8'h01; tick(); req = 0;
        close_p = 1; arm = 4'b1000; tick(); close_p = 0; arm = 0;
        chk("drain_state", state, 2); chk("drain_armed", armed, 0);
        chk("drain_valid", v_valid, 1); chk("drain_booth", v_booth, 0);
        ready = 1; tick();
        chk("drain_ack", ack, 4'b0001); chk("drain_hold", state, 2); chk("drain_total", total, 7);
        tick();
        chk("closed_state", state, 3); chk("closed_results", res_valid, 1);
        open_p = 1; tick(); open_p = 0;
        chk("closed_ign_open", state, 3);
        clear_p = 1; tick(); clear_p = 0;
        chk("clear_state", state, 0); chk("clear_results", res_valid, 0); chk("clear_total", total, 7);

        // reset mid-transaction
        ready = 0;
        open_p = 1; tick(); open_p = 0;
        arm = 4'b0001; tick(); arm = 0;
        req = 4'b0001; cand = 8'h01; tick(); req = 0;
        tick();
        chk("mid_valid", v_valid, 1);
        rst = 1; tick();
        chk("mid_rst_valid", v_valid, 0); chk("mid_rst_state", state, 0);
        chk("mid_rst_cand", v_cand, 0); chk("mid_rst_total", total, 0);
        rst = 0;

        // arm timeout
        open_p = 1; tick(); open_p = 0;
        arm = 4'b1000; tick(); arm = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
`ifdef VOTE_TIMEOUT_EN
            if (i < 8) begin
                chk("to_wait", tmo, 0); chk("to_armed", armed, 4'b1000);
            end else begin
                chk("to_pulse", tmo, 4'b1000); chk("to_disarm", armed, 0);
            end
`else
            chk("to_none", tmo, 0); chk("to_held", armed, 4'b1000);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
